ser2par_rx: RTL and testbench
=============================

Name: ser2par_rx

Overview:
- Serial-to-parallel frame receiver; the stage directly upstream of the 4-bit enabled register.
- Deframes start / WIDTH data bits / stop from a 1-bit line.
- Presents the assembled word on data, with a one-cycle data_valid pulse wired straight to the register's en input.
- Flags bad framing on frame_err.

Parameters:
WIDTH, 4, data bits per frame (≥2); data/in width of the downstream register.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
bit_en  input  1  bit strobe; line sampled and FSM advances only on cycles with bit_en=1
sin  input  1  serial line, idle high
data  output  WIDTH  last good received word; LSB = first data bit
data_valid  output  1  one-cycle pulse, data updated this cycle
frame_err  output  1  one-cycle pulse, bad stop bit (or parity, if enabled)
busy  output  1  high while FSM not in IDLE

Behaviour:
- Reset (rstn=0, async, any time incl. mid-frame):
  - FSM→IDLE; shift reg=0; bit count=0.
  - data=0, data_valid=0, frame_err=0, busy=0.
- All outputs are registered. busy is decoded from state.
- Cycles with bit_en=0: state, count and shift reg hold. data_valid and frame_err are forced to 0, so pulses are exactly one clk wide.
- States: IDLE, DATA, PAR (exists only with the optional feature), STOP.
- IDLE:
  - bit_en & sin=0 → DATA, count=0.
  - sin=1 stays IDLE.
- DATA:
  - On bit_en: shift reg[count] <= sin and count++.
  - When count==WIDTH-1 → PAR if compiled in, else STOP.
  - Count width is clog2(WIDTH); no wrap possible.
- STOP, on bit_en:
  - sin=1 and no pending parity error → data <= shift reg, data_valid=1 on the following clk edge.
  - Otherwise frame_err=1, data unchanged.
  - Either case → IDLE.
- Latency: data/data_valid update on the clk edge of the stop-bit strobe; visible one cycle after the bit_en cycle that sampled the stop bit.
- Back-to-back frames: a start bit on the strobe immediately after STOP is accepted; no idle bit required.
- Error frame: data keeps the previous good value; data_valid is not asserted.
- data_valid and frame_err are never high together.
- No recovery search: after frame_err the receiver returns to IDLE and waits for the next sin=0 strobe.

Optional Feature:
- Macro SER2PAR_RX_PARITY_EN.
- Defined:
  - PAR state after DATA samples an even-parity bit on bit_en.
  - Mismatch (XOR of data bits ≠ parity bit) sets an internal par_err flag.
  - STOP then reports frame_err instead of data_valid regardless of the stop-bit value.
  - par_err is cleared in IDLE.
  - Frame length = WIDTH+3 strobes.
- Undefined:
  - No PAR state, no par_err.
  - Frame length = WIDTH+2 strobes.
  - The port list is identical in both builds.

Decomposition:
- Shared package/include, ser2par_pkg:
  - State encodings as localparams (IDLE=0, DATA=1, PAR=2, STOP=3; 2 bits).
  - Default WIDTH.
  - Idle line level constant (1'b1).
- One natural sub-module: ser2par_shift, a WIDTH-bit indexed capture register with load strobe, async active-low clear, and parallel output. FSM and output regs remain in the top module.

Test Plan:
- Reset/idle: rstn=0 for 2 clks, then sin=1, bit_en=1 for 10 clks → data=0, data_valid=0, frame_err=0, busy=0 throughout.
- Good frame, bit_en every clk: sin sequence 0,1,0,0,1,1 (data 4'b1001) → data=4'b1001, single data_valid pulse, busy high 5 cycles; downstream register Q=1001 next edge.
- Slow strobe: bit_en every 3rd clk sending 4'b1110 then back-to-back 4'b1101 → two data_valid pulses, each 1 clk wide, data 1110 then 1101; no gap bit needed.
- Bad stop: frame 0,1,1,0,1,0 → frame_err single pulse, data keeps previous 1101, no data_valid; next good 4'b1011 is received correctly.
- Reset mid-frame: assert rstn=0 after 2 data bits → immediate busy=0, data=0. After release, a full 4'b1111 frame → data=1111.
- SER2PAR_RX_PARITY_EN build:
  - 4'b1000 with parity 1 + stop 1 → data_valid, data=1000.
  - Same frame with parity 0 → frame_err, data unchanged.

Source files
------------

// File: rtl/ser2par_pkg.sv
// Shared definitions for the ser2par serial frame receiver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ser2par_pkg;

    // Receiver FSM state encodings (2 bits). PAR is only reachable when the
    // receiver is built with SER2PAR_RX_PARITY_EN defined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Default number of data bits per frame.
    localparam int DEFAULT_WIDTH = 4;

    // Level of the serial line when nothing is being sent; also the stop level.
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/ser2par_shift.sv
// Indexed capture register: writes din into bit idx when load is high.
// Latency: captured bit appears on q one clk after the load cycle.
// Backpressure: none; holds its contents whenever load is low.
//
// Ports:
//   clk, rstn  clock and asynchronous active-low clear
//   load       write enable for the addressed bit
//   idx        bit position to write (0 = first received data bit)
//   din        bit value to capture
//   q          parallel contents
module ser2par_shift
    import ser2par_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CW-1:0]    idx,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d[idx] = din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ser2par_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits (LSB first), stop bit.
// Latency: data/data_valid (or frame_err) registered on the edge of the stop-bit strobe.
// Backpressure: none; the line is sampled only on bit_en cycles and nothing stalls it.
//
// Optional build macro SER2PAR_RX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit; a parity mismatch turns the frame into frame_err.
// The port list is the same in both builds.
//
// Ports:
//   clk, rstn   clock (rising edge) and asynchronous active-low reset
//   bit_en      bit strobe; FSM advances and sin is sampled only when high
//   sin         serial line, idle high
//   data        last good received word
//   data_valid  one-clk pulse, data updated this cycle (drives downstream en)
//   frame_err   one-clk pulse, bad stop bit or parity
//   busy        high while a frame is in progress
module ser2par_rx
    import ser2par_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sh_q;
    logic             sh_load;
    logic             stop_ok;

`ifdef SER2PAR_RX_PARITY_EN
    logic par_err_q, par_err_d;
    // A parity failure already recorded overrides a good stop bit.
    assign stop_ok = (sin == IDLE_LINE) && !par_err_q;
`else
    assign stop_ok = (sin == IDLE_LINE);
`endif

    ser2par_shift #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shift (
        .clk  (clk),
        .rstn (rstn),
        .load (sh_load),
        .idx  (cnt_q),
        .din  (sin),
        .q    (sh_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dv_d    = 1'b0;          // pulses default low, so they last one clk
        fe_d    = 1'b0;
        sh_load = 1'b0;
`ifdef SER2PAR_RX_PARITY_EN
        par_err_d = (state_q == ST_IDLE) ? 1'b0 : par_err_q;
`endif
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (sin != IDLE_LINE) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    sh_load = 1'b1;
                    if (cnt_q == LAST) begin
                        // Park the count at zero rather than letting it wrap.
                        cnt_d = '0;
`ifdef SER2PAR_RX_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SER2PAR_RX_PARITY_EN
                ST_PAR: begin
                    // Even parity: the parity bit must equal the XOR of the data bits.
                    par_err_d = (^sh_q) != sin;
                    state_d   = ST_STOP;
                end
`endif
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (stop_ok) begin
                        data_d = sh_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Registered so busy tracks the state register without a decode after the flop.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SER2PAR_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ser2par_rx.sv
`timescale 1ns/1ps
module tb_ser2par_rx;

    localparam int W = 4;
`ifdef SER2PAR_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         bit_en = 1'b0;
    logic         sin = 1'b1;
    logic [W-1:0] data;
    logic         data_valid;
    logic         frame_err;
    logic         busy;

    always #5 clk = ~clk;

    ser2par_rx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bit_en     (bit_en),
        .sin        (sin),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct packed {
        logic         err;
        logic [W-1:0] word;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           busy_cnt = 0;
    logic [W-1:0] last_good = '0;
    logic [W-1:0] dreg;              // model of the downstream 4-bit enabled register

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) dreg <= '0;
        else if (data_valid) dreg <= data;
    end

    // Scoreboard: every output pulse must match the oldest pending frame result.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) busy_cnt++;
        if (data_valid === 1'b1 || frame_err === 1'b1) begin
            chk("dv_fe_exclusive", 32'(data_valid & frame_err), 32'd0);
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_data_valid", 32'(data_valid), 32'(!e.err));
                chk("sb_frame_err", 32'(frame_err), 32'(e.err));
                chk("sb_data", 32'(data), 32'(e.word));
            end
        end
    end

    task automatic tick(input logic en, input logic s);
        bit_en = en;
        sin    = s;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic strobe(input logic s, input int p);
        tick(1'b1, s);
        for (int i = 1; i < p; i++) tick(1'b0, s);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic par, input int p);
        logic good;
        good = stop && (!PAR_EN || (par == ^w));
        if (good) begin
            sb.push_back({1'b0, w});
            last_good = w;
        end else begin
            sb.push_back({1'b1, last_good});
        end
        strobe(1'b0, p);
        for (int i = 0; i < W; i++) strobe(w[i], p);
        if (PAR_EN) strobe(par, p);
        strobe(stop, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    endtask

    initial begin
        // Reset held for two clocks
        repeat (2) begin
            @(negedge clk);
            chk("rst_data", 32'(data), 32'd0);
            chk("rst_dv", 32'(data_valid), 32'd0);
            chk("rst_fe", 32'(frame_err), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;

        // Idle line with strobes: nothing happens
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            @(negedge clk);
            chk("idle_data", 32'(data), 32'd0);
            chk("idle_dv", 32'(data_valid), 32'd0);
            chk("idle_fe", 32'(frame_err), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Good frame, strobe every clock
        busy_cnt = 0;
        send_frame(4'b1001, 1'b1, 1'b0, 1);
        chk("f1_dv_latency", 32'(data_valid), 32'd1);
        chk("f1_data_now", 32'(data), 32'h9);
        idle(2);
        chk("f1_busy_cycles", 32'(busy_cnt), 32'(W + 1 + int'(PAR_EN)));
        chk("f1_data", 32'(data), 32'h9);
        chk("f1_downstream_q", 32'(dreg), 32'h9);
        chk("f1_sb_empty", 32'(sb.size()), 32'd0);

        // Slow strobe, two back-to-back frames with no idle bit between them
        send_frame(4'b1110, 1'b1, 1'b1, 3);
        chk("f2_data", 32'(data), 32'hE);
        send_frame(4'b1101, 1'b1, 1'b1, 3);
        idle(3);
        chk("f3_data", 32'(data), 32'hD);
        chk("f3_downstream_q", 32'(dreg), 32'hD);
        chk("f3_sb_empty", 32'(sb.size()), 32'd0);

        // Bad stop bit: error pulse, previous word kept
        send_frame(4'b1011, 1'b0, 1'b1, 1);
        chk("bad_fe_latency", 32'(frame_err), 32'd1);
        chk("bad_dv", 32'(data_valid), 32'd0);
        idle(2);
        chk("bad_data_kept", 32'(data), 32'hD);
        send_frame(4'b1011, 1'b1, 1'b1, 1);
        idle(2);
        chk("recover_data", 32'(data), 32'hB);
        chk("recover_sb_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a frame, after two data bits
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        last_good = '0;
        sin = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        send_frame(4'b1111, 1'b1, 1'b0, 1);
        idle(2);
        chk("post_rst_data", 32'(data), 32'hF);

        // Parity cases (without parity compiled in, both are plain good frames)
        send_frame(4'b1000, 1'b1, 1'b1, 1);
        idle(2);
        chk("par_good_data", 32'(data), 32'h8);
        send_frame(4'b1000, 1'b1, 1'b0, 1);
        chk("par_bad_fe", 32'(frame_err), 32'(PAR_EN));
        idle(2);
        chk("par_bad_data", 32'(data), 32'h8);

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
